instr_decode_queue: RTL

Decode stage with a parametrised decoded-instruction queue between fetch and execute. Each accepted 32-bit ARM instruction is classified and split into fields at write time (data processing, single data transfer, branch, and multiply, which is new). The decoded entry and its PC tag are stored in a DEPTH-entry FIFO. Valid/ready handshakes on both sides and a flush input let the pipeline stall and discard wrong-path instructions after a taken branch.

---
 rtl/instr_decode_queue_pkg.sv | 36 +++
 rtl/instr_decode_queue_if.sv | 54 +++++
 rtl/instr_decode_queue_field_decode.sv | 52 +++++
 rtl/instr_decode_queue.sv | 88 ++++++++
 4 files changed

// File: rtl/instr_decode_queue_pkg.sv
// Shared types for the decode stage: internal opcodes and the decoded-entry payload.
package decode_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned COND_W  = 4;
    localparam int unsigned OPC_W   = 5;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned SHIFT_W = 12;
    localparam int unsigned BIMM_W  = 24;

    localparam logic [OPC_W-1:0] OP_LDST    = 5'h10;
    localparam logic [OPC_W-1:0] OP_BRANCH  = 5'h11;
    localparam logic [OPC_W-1:0] OP_MUL     = 5'h12;
    localparam logic [OPC_W-1:0] OP_INVALID = 5'h1F;

    typedef struct packed {
        logic [COND_W-1:0]  cond;
        logic [OPC_W-1:0]   opcode;
        logic [REG_W-1:0]   rn;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   rm;
        logic [REG_W-1:0]   rs;
        logic               imm_op;
        logic               cpsr_write;
        logic               accumulate;
        logic               pre_post;
        logic               up_down;
        logic               byte_word;
        logic               write_back;
        logic               load_store;
        logic               link;
        logic [SHIFT_W-1:0] shifter;
        logic [BIMM_W-1:0]  branch_imm;
    } decoded_t;

endpackage

// File: rtl/instr_decode_queue_if.sv
// Fetch-side and execute-side handshake bundle for the decoded-instruction queue.
interface instr_decode_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [3:0]        out_cond;
    logic [4:0]        out_opcode;
    logic [3:0]        out_rn;
    logic [3:0]        out_rd;
    logic [3:0]        out_rm;
    logic [3:0]        out_rs;
    logic              out_imm_op;
    logic              out_cpsr_write;
    logic              out_accumulate;
    logic              out_pre_post;
    logic              out_up_down;
    logic              out_byte_word;
    logic              out_write_back;
    logic              out_load_store;
    logic              out_link;
    logic [11:0]       out_shifter;
    logic [23:0]       out_branch_imm;
    logic [CNT_W-1:0]  count;

    // Pipeline environment (fetch + execute) side.
    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_cond, out_opcode,
               out_rn, out_rd, out_rm, out_rs, out_imm_op, out_cpsr_write,
               out_accumulate, out_pre_post, out_up_down, out_byte_word,
               out_write_back, out_load_store, out_link, out_shifter,
               out_branch_imm, count
    );

    // Queue side.
    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_cond, out_opcode,
               out_rn, out_rd, out_rm, out_rs, out_imm_op, out_cpsr_write,
               out_accumulate, out_pre_post, out_up_down, out_byte_word,
               out_write_back, out_load_store, out_link, out_shifter,
               out_branch_imm, count
    );
endinterface

// File: rtl/instr_decode_queue_field_decode.sv
// Combinational ARM instruction classifier and field splitter.
module instr_field_decode
    import decode_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output decoded_t           dec
);

    // Priority: invalid cond, multiply, data processing, load/store, branch, invalid.
    always_comb begin
        dec      = '0;
        dec.cond = instr[31:28];
        if (instr[31:28] == 4'b1111) begin
            dec.opcode = OP_INVALID;
        end else if (instr[27:22] == 6'b000000 && instr[7:4] == 4'b1001) begin
            dec.opcode     = OP_MUL;
            dec.rd         = instr[19:16];
            dec.rn         = instr[15:12];
            dec.rs         = instr[11:8];
            dec.rm         = instr[3:0];
            dec.cpsr_write = instr[20];
            dec.accumulate = instr[21];
        end else if (instr[27:26] == 2'b00) begin
            dec.opcode     = {1'b0, instr[24:21]};
            dec.rn         = instr[19:16];
            dec.rd         = instr[15:12];
            dec.rm         = instr[3:0];
            dec.imm_op     = instr[25];
            dec.shifter    = instr[11:0];
            dec.cpsr_write = instr[20];
        end else if (instr[27:26] == 2'b01) begin
            dec.opcode     = OP_LDST;
            dec.pre_post   = instr[24];
            dec.up_down    = instr[23];
            dec.byte_word  = instr[22];
            dec.write_back = instr[21];
            dec.load_store = instr[20];
            dec.rn         = instr[19:16];
            dec.rd         = instr[15:12];
            dec.rm         = instr[3:0];
            dec.imm_op     = instr[25];
            dec.shifter    = instr[11:0];
        end else if (instr[27:25] == 3'b101) begin
            dec.opcode     = OP_BRANCH;
            dec.link       = instr[24];
            dec.branch_imm = instr[23:0];
        end else begin
            dec.opcode = OP_INVALID;
        end
    end

endmodule

// File: rtl/instr_decode_queue.sv
// Decode stage: decodes each accepted instruction and queues it with its PC tag.
module instr_decode_queue
    import decode_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_decode_queue_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    decoded_t          dec_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    decoded_t          in_dec;
    decoded_t          head;
    logic              out_valid;
    logic              push;
    logic              pop;

    instr_field_decode u_decode (
        .instr (bus.in_instr),
        .dec   (in_dec)
    );

    assign out_valid    = (count != '0);
    assign bus.in_ready = (count < CNT_W'(DEPTH)) & ~bus.flush;
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = out_valid & bus.out_ready & ~bus.flush;

    // Storage is left unreset; only pointers and count carry validity.
    always_ff @(posedge clk) begin
        if (push) begin
            dec_mem[wr_ptr] <= in_dec;
            pc_mem[wr_ptr]  <= bus.in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Empty queue presents an all-zero head.
    assign head           = out_valid ? dec_mem[rd_ptr] : '0;
    assign bus.out_pc     = out_valid ? pc_mem[rd_ptr] : '0;
    assign bus.out_valid  = out_valid;
    assign bus.count      = count;

    assign bus.out_cond       = head.cond;
    assign bus.out_opcode     = head.opcode;
    assign bus.out_rn         = head.rn;
    assign bus.out_rd         = head.rd;
    assign bus.out_rm         = head.rm;
    assign bus.out_rs         = head.rs;
    assign bus.out_imm_op     = head.imm_op;
    assign bus.out_cpsr_write = head.cpsr_write;
    assign bus.out_accumulate = head.accumulate;
    assign bus.out_pre_post   = head.pre_post;
    assign bus.out_up_down    = head.up_down;
    assign bus.out_byte_word  = head.byte_word;
    assign bus.out_write_back = head.write_back;
    assign bus.out_load_store = head.load_store;
    assign bus.out_link       = head.link;
    assign bus.out_shifter    = head.shifter;
    assign bus.out_branch_imm = head.branch_imm;

endmodule
